uart_result_streamer: RTL and testbench
=======================================

UART_RESULT_STREAMER -- requirements
Module: uart_result_streamer

Interface
REQ-001 Parameter BITWIDTH, default 8: result word width; legal range 4..32.
REQ-002 Parameter CHANNELS, default 2: result banks (array columns) per row.
REQ-003 Parameter DEPTH, default 4: rows per bank.
REQ-004 Derived widths: CH_W = max(1,$clog2(CHANNELS)); ADDR_W = max(1,$clog2(DEPTH)); NBYTES = ceil(BITWIDTH/8); NHEX = ceil(BITWIDTH/4).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 CLK  in  1  system clock; every register updates on the rising edge.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 START  in  1  level request to stream one frame; the block acts on its rising edge.
REQ-009 MODE  in  1  0 = raw binary bytes, 1 = ASCII hex text.
REQ-010 RD_CH  out  CH_W  result bank select.
REQ-011 RD_ADDR  out  ADDR_W  row address within the bank.
REQ-012 RD_DATA  in  BITWIDTH  bank read data; valid exactly 1 cycle after RD_CH/RD_ADDR.
REQ-013 TX_DATA  out  8  byte to the UART transmitter.
REQ-014 TX_VALID  out  1  byte-offer strobe to the transmitter write input.
REQ-015 TX_BUSY  in  1  transmitter busy flag.
REQ-016 BUSY  out  1  high from frame start until the block returns to IDLE.
REQ-017 DONE  out  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT_RD, LATCH, SEND, HOLD, NEXT, REARM.
REQ-019 IDLE: on START rising edge, latch MODE, clear row/channel counters, go to FETCH; otherwise stay.
REQ-020 FETCH drives RD_CH/RD_ADDR from the counters. WAIT_RD waits 1 cycle. LATCH captures RD_DATA into a word register and loads the byte/digit index.
REQ-021 Traversal order is row-major: for row 0..DEPTH-1, for channel 0..CHANNELS-1.
REQ-022 Binary mode: send NBYTES bytes per word, most-significant byte first, upper unused bits zero.
REQ-023 ASCII mode: send NHEX uppercase hex digits per word, MSD first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46). Then send 0x2C (',') after each non-last channel and 0x0A after the last channel of a row.
REQ-024 SEND: assert TX_VALID with TX_DATA stable. The byte is accepted in the first cycle where TX_VALID=1 and TX_BUSY=0. Go to HOLD on the next edge with TX_VALID deasserted.
REQ-025 TX_VALID is never high for more than one cycle after acceptance. TX_DATA does not change while TX_VALID is high.
REQ-026 HOLD waits until TX_BUSY=0, then advances to the next byte (SEND) or to NEXT when the word is exhausted.
REQ-027 NEXT increments the channel. When the channel is CHANNELS-1 it wraps the channel to 0 and increments the row.
REQ-028 NEXT goes to FETCH, or, after row DEPTH-1 / channel CHANNELS-1, pulses DONE and goes to REARM.
REQ-029 REARM waits for START=0, then goes to IDLE. A START held high yields exactly one frame.
REQ-030 START edges while BUSY=1 are ignored. MODE changes during a frame have no effect.
REQ-031 Frame length: CHANNELS*DEPTH*NBYTES bytes in binary mode; CHANNELS*DEPTH*(NHEX+1) bytes in ASCII mode.
REQ-032 Zero-latency assumption forbidden: the block never reads RD_DATA in the same cycle the address is driven.

Reset
REQ-033 RST=1 at any edge forces IDLE, counters 0, TX_VALID=0, TX_DATA=0, RD_CH=0, RD_ADDR=0, BUSY=0, DONE=0 on that edge.
REQ-034 Reset mid-frame aborts the frame with no DONE pulse.
REQ-035 A START that is still high when RST falls does not start a frame; a new rising edge is required.

Structure
REQ-036 Shared package holds the state enumeration, the ASCII constants (0x2C, 0x0A, digit/letter offsets) and the width-derivation functions.
REQ-037 One sub-module, hex_ascii_enc: combinational 4-bit to ASCII byte encoder, instantiated once.
REQ-038 All arithmetic is unsigned. Counters wrap only as specified in REQ-027/REQ-028.

Verification
REQ-039 CHANNELS=2, DEPTH=2, BITWIDTH=8, MODE=0, banks {ch0:12,56; ch1:34,78} -> TX bytes 12 34 56 78, then one DONE pulse.
REQ-040 Same data, MODE=1 -> bytes 31 32 2C 33 34 0A 35 36 2C 37 38 0A, then DONE.
REQ-041 BITWIDTH=16, single word 0xABCD, MODE=0 -> AB CD; MODE=1 -> 41 42 43 44 0A.
REQ-042 Hold TX_BUSY=1 for 100 cycles during SEND -> TX_VALID stays high with TX_DATA unchanged; no byte is lost or duplicated.
REQ-043 RST pulse after the 2nd byte -> all outputs zero on the next edge, no DONE; the next START edge restarts the frame from row 0, channel 0.
REQ-044 START held high for 3 frame-lengths -> exactly one frame is sent. A START edge during BUSY is ignored.

Source files
------------

// File: rtl/uart_result_streamer_pkg.sv
// Shared state codes, ASCII constants and width helpers
// for the UART result streamer.
package uart_result_streamer_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_REARM   = 3'd7;

  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_DIGIT = 8'h30;
  localparam logic [7:0] ASC_ALPHA = 8'h41;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int nbytes_of(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int nhex_of(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/uart_result_streamer_hex_ascii_enc.sv
// Nibble to uppercase ASCII hex digit.
// Purely combinational.
module hex_ascii_enc
  import uart_result_streamer_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    if (nib < 4'd10) asc = ASC_DIGIT + {4'd0, nib};
    else             asc = ASC_ALPHA + {4'd0, nib} - 8'd10;
  end

endmodule

// File: rtl/uart_result_streamer.sv
// Streams a bank array row-major to a UART transmitter,
// as raw bytes or as comma/newline separated hex text.
module uart_result_streamer
  import uart_result_streamer_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               START,
  input  logic                               MODE,
  output logic [clog2_min1(CHANNELS)-1:0]    RD_CH,
  output logic [clog2_min1(DEPTH)-1:0]       RD_ADDR,
  input  logic [BITWIDTH-1:0]                RD_DATA,
  output logic [7:0]                         TX_DATA,
  output logic                               TX_VALID,
  input  logic                               TX_BUSY,
  output logic                               BUSY,
  output logic                               DONE
);

  localparam int CH_W   = clog2_min1(CHANNELS);
  localparam int ADDR_W = clog2_min1(DEPTH);
  localparam int NBYTES = nbytes_of(BITWIDTH);
  localparam int NHEX   = nhex_of(BITWIDTH);
  localparam int WW     = 8 * NBYTES;

  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        BIN_LAST = 4'(NBYTES - 1);
  localparam logic [3:0]        HEX_LAST = 4'(NHEX);

  logic [2:0]        state_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] row_q;
  logic [WW-1:0]     word_q;
  logic [3:0]        idx_q;
  logic              mode_q;
  logic              start_q;
  logic              done_q;

  logic [3:0] nib;
  logic [7:0] hex_byte;
  logic [7:0] bin_byte;
  logic [7:0] cur_byte;
  logic       last_sym;
  int         bin_sh;
  int         hex_sh;

  hex_ascii_enc u_enc (
    .nib (nib),
    .asc (hex_byte)
  );

  // In text mode index HEX_LAST is the separator slot.
  always_comb begin
    bin_sh = 0;
    hex_sh = 0;
    if (idx_q <= BIN_LAST)
      bin_sh = 8 * (NBYTES - 1 - int'(idx_q));
    if (idx_q < HEX_LAST)
      hex_sh = 4 * (NHEX - 1 - int'(idx_q));
    bin_byte = 8'(word_q >> bin_sh);
    nib      = 4'(word_q >> hex_sh);
    last_sym = (idx_q == (mode_q ? HEX_LAST : BIN_LAST));
    if (!mode_q)
      cur_byte = bin_byte;
    else if (idx_q == HEX_LAST)
      cur_byte = (ch_q == CH_LAST) ? ASC_LF : ASC_COMMA;
    else
      cur_byte = hex_byte;
  end

  assign TX_VALID = (state_q == S_SEND);
  assign TX_DATA  = TX_VALID ? cur_byte : 8'h00;
  assign RD_CH    = ch_q;
  assign RD_ADDR  = row_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      row_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      // A START still high at release is not an edge.
      start_q <= START;
    end else begin
      start_q <= START;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START && !start_q) begin
            mode_q  <= MODE;
            ch_q    <= '0;
            row_q   <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH:   state_q <= S_WAIT_RD;
        S_WAIT_RD: state_q <= S_LATCH;
        S_LATCH: begin
          word_q  <= WW'(RD_DATA);
          idx_q   <= '0;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (!TX_BUSY) state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (!TX_BUSY) begin
            if (last_sym) begin
              state_q <= S_NEXT;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= S_SEND;
            end
          end
        end
        S_NEXT: begin
          if (ch_q == CH_LAST) begin
            ch_q <= '0;
            if (row_q == ROW_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_REARM;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_REARM: begin
          if (!START) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_streamer.sv
// Scoreboard bench: a 2x2x8 instance and a 1x1x16 instance,
// each with a bank model and a simple busy-after-accept UART.
module tb_uart_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start8, mode8, start16, mode16, force8;

  logic [0:0]  rd_ch8, rd_addr8;
  logic [7:0]  rd_data8, td8;
  logic        tv8, tb8, busy8, done8;

  logic [0:0]  rd_ch16, rd_addr16;
  logic [15:0] rd_data16;
  logic [7:0]  td16;
  logic        tv16, tb16, busy16, done16;

  logic [7:0] mem8 [2][2];
  int bc8 = 0;
  int bc16 = 0;

  int total = 0;
  int bad = 0;
  int acc8 = 0;
  int done_n8 = 0;
  int done_n16 = 0;

  logic [8:0] q8[$];
  logic [8:0] q16[$];
  logic [8:0] exp8, exp16;
  logic       pv8 = 1'b0;
  logic [7:0] pd8 = 8'h00;

  uart_result_streamer #(.BITWIDTH(8), .CHANNELS(2), .DEPTH(2)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .MODE(mode8),
    .RD_CH(rd_ch8), .RD_ADDR(rd_addr8), .RD_DATA(rd_data8),
    .TX_DATA(td8), .TX_VALID(tv8), .TX_BUSY(tb8),
    .BUSY(busy8), .DONE(done8)
  );

  uart_result_streamer #(.BITWIDTH(16), .CHANNELS(1), .DEPTH(1)) dut16 (
    .CLK(clk), .RST(rst), .START(start16), .MODE(mode16),
    .RD_CH(rd_ch16), .RD_ADDR(rd_addr16), .RD_DATA(rd_data16),
    .TX_DATA(td16), .TX_VALID(tv16), .TX_BUSY(tb16),
    .BUSY(busy16), .DONE(done16)
  );

  assign tb8  = force8 || (bc8 != 0);
  assign tb16 = (bc16 != 0);

  always @(posedge clk) begin
    rd_data8  <= mem8[rd_ch8][rd_addr8];
    rd_data16 <= (rd_ch16 == 1'b0 && rd_addr16 == 1'b0) ? 16'hABCD : 16'h0000;
    if (tv8 && !tb8) bc8 <= 3;
    else if (bc8 > 0) bc8 <= bc8 - 1;
    if (tv16 && !tb16) bc16 <= 3;
    else if (bc16 > 0) bc16 <= bc16 - 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tv8 && !tb8) begin
        total++;
        acc8++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL byte8: got %03h required none", {1'b0, td8});
        end else begin
          exp8 = q8.pop_front();
          if (exp8 !== {1'b0, td8}) begin
            bad++;
            $display("FAIL byte8: got %03h required %03h", {1'b0, td8}, exp8);
          end
        end
      end
      if (done8) begin
        total++;
        done_n8++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL done8: got DONE required none");
        end else begin
          exp8 = q8.pop_front();
          if (exp8 !== 9'h100) begin
            bad++;
            $display("FAIL done8: got 100 required %03h", exp8);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tv16 && !tb16) begin
        total++;
        if (q16.size() == 0) begin
          bad++;
          $display("FAIL byte16: got %03h required none", {1'b0, td16});
        end else begin
          exp16 = q16.pop_front();
          if (exp16 !== {1'b0, td16}) begin
            bad++;
            $display("FAIL byte16: got %03h required %03h", {1'b0, td16}, exp16);
          end
        end
      end
      if (done16) begin
        total++;
        done_n16++;
        if (q16.size() == 0) begin
          bad++;
          $display("FAIL done16: got DONE required none");
        end else begin
          exp16 = q16.pop_front();
          if (exp16 !== 9'h100) begin
            bad++;
            $display("FAIL done16: got 100 required %03h", exp16);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pv8 && tv8) begin
      total++;
      if (td8 !== pd8) begin
        bad++;
        $display("FAIL tx_stable: got %02h required %02h", td8, pd8);
      end
    end
    pv8 <= tv8 && tb8;
    pd8 <= td8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic expect_bytes(input bit d16, input logic [95:0] v,
                              input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      logic [8:0] e;
      e = {1'b0, v[8*(n-1-i) +: 8]};
      if (d16) q16.push_back(e);
      else     q8.push_back(e);
    end
    if (with_done) begin
      if (d16) q16.push_back(9'h100);
      else     q8.push_back(9'h100);
    end
  endtask

  task automatic pulse_start(input bit d16);
    if (d16) start16 = 1'b1;
    else     start8 = 1'b1;
    tick();
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input bit d16, input int target);
    int n;
    int got;
    n = 0;
    got = d16 ? done_n16 : done_n8;
    while (got < target && n < 3000) begin
      tick();
      n++;
      got = d16 ? done_n16 : done_n8;
    end
    chk(d16 ? "done_wait16" : "done_wait8", got, target);
    repeat (3) tick();
    chk(d16 ? "drain16" : "drain8", d16 ? q16.size() : q8.size(), 0);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_valid"}, tv8, 0);
    chk({tag, "_data"}, td8, 0);
    chk({tag, "_rdch"}, rd_ch8, 0);
    chk({tag, "_rdaddr"}, rd_addr8, 0);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_done"}, done8, 0);
  endtask

  initial begin
    int n;
    int base;
    logic [7:0] held;
    rst = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    mode8 = 1'b0;
    mode16 = 1'b0;
    force8 = 1'b0;
    mem8[0][0] = 8'h12;
    mem8[0][1] = 8'h56;
    mem8[1][0] = 8'h34;
    mem8[1][1] = 8'h78;
    repeat (3) tick();
    chk_zero8("reset");
    chk("reset_busy16", busy16, 0);
    rst = 1'b0;
    tick();

    expect_bytes(0, 96'({8'h12, 8'h34, 8'h56, 8'h78}), 4, 1);
    pulse_start(0);
    wait_done(0, 1);

    mode8 = 1'b1;
    expect_bytes(0, {8'h31, 8'h32, 8'h2C, 8'h33, 8'h34, 8'h0A,
                     8'h35, 8'h36, 8'h2C, 8'h37, 8'h38, 8'h0A}, 12, 1);
    pulse_start(0);
    repeat (5) tick();
    mode8 = 1'b0;
    wait_done(0, 2);

    expect_bytes(1, 96'({8'hAB, 8'hCD}), 2, 1);
    pulse_start(1);
    wait_done(1, 1);
    mode16 = 1'b1;
    expect_bytes(1, 96'({8'h41, 8'h42, 8'h43, 8'h44, 8'h0A}), 5, 1);
    pulse_start(1);
    wait_done(1, 2);

    mem8[0][0] = 8'h9F;
    mem8[0][1] = 8'hA0;
    mem8[1][0] = 8'h0B;
    mem8[1][1] = 8'hFF;
    expect_bytes(0, 96'({8'h9F, 8'h0B, 8'hA0, 8'hFF}), 4, 1);
    pulse_start(0);
    wait_done(0, 3);
    mode8 = 1'b1;
    expect_bytes(0, {8'h39, 8'h46, 8'h2C, 8'h30, 8'h42, 8'h0A,
                     8'h41, 8'h30, 8'h2C, 8'h46, 8'h46, 8'h0A}, 12, 1);
    pulse_start(0);
    wait_done(0, 4);

    mode8 = 1'b0;
    expect_bytes(0, 96'({8'h9F, 8'h0B, 8'hA0, 8'hFF}), 4, 1);
    pulse_start(0);
    n = 0;
    while (!tv8 && n < 200) begin
      tick();
      n++;
    end
    chk("hold_offer", tv8, 1);
    force8 = 1'b1;
    held = td8;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("hold_keep", {tv8, td8}, {1'b1, held});
    end
    force8 = 1'b0;
    wait_done(0, 5);

    expect_bytes(0, 96'({8'h9F, 8'h0B}), 2, 0);
    base = acc8;
    start8 = 1'b1;
    tick();
    n = 0;
    while (acc8 < base + 2 && n < 500) begin
      tick();
      n++;
    end
    chk("abort_two_bytes", acc8 - base, 2);
    rst = 1'b1;
    tick();
    chk_zero8("abort");
    rst = 1'b0;
    repeat (40) tick();
    chk("abort_no_restart", busy8, 0);
    chk("abort_no_done", done_n8, 5);
    chk("abort_queue", q8.size(), 0);
    start8 = 1'b0;
    tick();
    expect_bytes(0, 96'({8'h9F, 8'h0B, 8'hA0, 8'hFF}), 4, 1);
    pulse_start(0);
    wait_done(0, 6);

    expect_bytes(0, 96'({8'h9F, 8'h0B, 8'hA0, 8'hFF}), 4, 1);
    start8 = 1'b1;
    repeat (6) tick();
    start8 = 1'b0;
    repeat (2) tick();
    start8 = 1'b1;
    repeat (200) tick();
    chk("held_one_frame", done_n8, 7);
    chk("held_rearm_busy", busy8, 1);
    start8 = 1'b0;
    repeat (10) tick();
    chk("held_idle", busy8, 0);
    chk("held_queue", q8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
